// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the up-counting mm:ss stopwatch.
// Holds the FSM encoding and the binary-to-two-digit BCD helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    SAT   = 2'd3
  } state_t;

  localparam logic [6:0] SEC_MAX = 7'd59;
  localparam int         BCD_W   = 4;

  // Two BCD digits {tens, units} of a value in 0..99.
  function automatic logic [2*BCD_W-1:0] bcd2(input logic [6:0] v);
    return {BCD_W'(v / 7'd10), BCD_W'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/stopwatch_up_edge_detector.sv
// Rising-edge detector for button levels, synchronous active-high reset.
// Pulse is combinational from the input and a one-cycle history register.
module edge_detector (
  input  logic clock,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clock) begin
    if (rst) din_q <= 1'b0;
    else     din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/stopwatch_up.sv
// Up-counting mm:ss stopwatch with start/pause/stop, saturating at MAX_MIN:59.
// Optional lap-hold display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_up
  import stopwatch_pkg::*;
#(
  parameter int TICK_COUNT = 100_000_000,
  parameter int MAX_MIN    = 99
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
`ifdef STOPWATCH_LAP_EN
  input  logic        lap,
`endif
  output logic [6:0]  min,
  output logic [6:0]  sec,
  output logic [15:0] dig,
  output logic        running,
  output logic        overflow,
  output logic        done
);

  localparam int TW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;

  logic   start_e, pause_e, stop_e;
  state_t state, next;
  logic [TW-1:0] tick_cnt;
  logic [6:0] min_q, sec_q, disp_min, disp_sec;
  logic tick, at_max, stop_acc;

  edge_detector u_start (.clock(clock), .rst(~reset), .din(start), .rise(start_e));
  edge_detector u_pause (.clock(clock), .rst(~reset), .din(pause), .rise(pause_e));
  edge_detector u_stop  (.clock(clock), .rst(~reset), .din(stop),  .rise(stop_e));

  assign tick     = (state == RUN) && (tick_cnt == TW'(TICK_COUNT - 1));
  assign at_max   = (min_q == 7'(MAX_MIN)) && (sec_q == SEC_MAX);
  assign stop_acc = stop_e && (state == RUN || state == PAUSE || state == SAT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= next;
      done  <= stop_acc;
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (!stop_e && start_e) next = RUN;
      RUN: begin
        if (stop_e)             next = IDLE;
        else if (pause_e)       next = PAUSE;
        else if (tick && at_max) next = SAT;
      end
      PAUSE: begin
        if (stop_e)                  next = IDLE;
        else if (pause_e || start_e) next = RUN;
      end
      SAT:     if (stop_e) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    running  = (state == RUN);
    overflow = (state == SAT);
  end

  // Tick counter only advances in RUN, so PAUSE keeps the sub-second phase.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tick_cnt <= '0;
      min_q    <= 7'd0;
      sec_q    <= 7'd0;
    end else if (next == IDLE) begin
      tick_cnt <= '0;
      min_q    <= 7'd0;
      sec_q    <= 7'd0;
    end else begin
      if (state == RUN)
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick && !at_max) begin
        if (sec_q == SEC_MAX) begin
          sec_q <= 7'd0;
          min_q <= min_q + 7'd1;
        end else begin
          sec_q <= sec_q + 7'd1;
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic       lap_e, lap_hold;
  logic [6:0] lap_min, lap_sec;

  edge_detector u_lap (.clock(clock), .rst(~reset), .din(lap), .rise(lap_e));

  // Hold only survives while staying in RUN; any other destination drops it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lap_hold <= 1'b0;
      lap_min  <= 7'd0;
      lap_sec  <= 7'd0;
    end else if (next != RUN) begin
      lap_hold <= 1'b0;
    end else if (state == RUN && lap_e) begin
      lap_hold <= ~lap_hold;
      if (!lap_hold) begin
        lap_min <= min_q;
        lap_sec <= sec_q;
      end
    end
  end

  assign disp_min = lap_hold ? lap_min : min_q;
  assign disp_sec = lap_hold ? lap_sec : sec_q;
`else
  assign disp_min = min_q;
  assign disp_sec = sec_q;
`endif

  assign min = disp_min;
  assign sec = disp_sec;
  assign dig = {bcd2(disp_min), bcd2(disp_sec)};

endmodule
